// File: rtl/ro_measure_sequencer.sv
// Sequencer for a bank of ring-oscillator counters: clear, gate, settle, capture, one channel at a time.
// Optional build macro RO_SEQ_CONTINUOUS_EN adds the continuous input for back-to-back sweeps.
module ro_measure_sequencer #(
   parameter int  NUM_CH        = 4,
   parameter int  COUNT_W       = 24,
   parameter int  CLEAR_CYCLES  = 2,
   parameter int  GATE_CYCLES   = 1024,
   parameter int  SETTLE_CYCLES = 4,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [NUM_CH-1:0]         ch_mask,
   input  logic [NUM_CH*COUNT_W-1:0] ro_count,
   output logic [NUM_CH-1:0]         ro_enable,
   output logic                      ro_reset,
   output logic                      busy,
   output logic                      done,
   output logic                      result_valid,
   output logic [CH_W-1:0]           result_ch,
   output logic [COUNT_W-1:0]        result_count
`ifdef RO_SEQ_CONTINUOUS_EN
   ,
   input  logic                      continuous
`endif
);

   localparam int MAX_CYC = (CLEAR_CYCLES > GATE_CYCLES)
                          ? ((CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES)
                          : ((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CLEAR_LD  = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_CAPTURE, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     ch, ch_nxt;
   logic [NUM_CH-1:0]   mask_q;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                mask_ld, capture, done_nxt, cont_en;
   logic [NUM_CH-1:0]   ro_enable_nxt;
   logic                ro_reset_nxt, busy_nxt;
   logic [CH_W:0]       first_in, first_q, next_q;
   logic [COUNT_W-1:0]  ch_count;

   // Returns {found, index} of the lowest set bit at or above 'from'.
   function automatic logic [CH_W:0] find_set(input logic [NUM_CH-1:0] m, input int from);
      logic [CH_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i >= from && m[i]) r = {1'b1, CH_W'(i)};
      end
      return r;
   endfunction

`ifdef RO_SEQ_CONTINUOUS_EN
   assign cont_en = continuous;
`else
   assign cont_en = 1'b0;
`endif

   assign first_in = find_set(ch_mask, 0);
   assign first_q  = find_set(mask_q, 0);
   assign next_q   = find_set(mask_q, int'(ch) + 1);
   assign ch_count = ro_count[int'(ch)*COUNT_W +: COUNT_W];

   always_comb begin
      // NOTE: every signal gets a default before the case, otherwise paths that skip it infer latches.
      state_nxt = state;
      ch_nxt    = ch;
      cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
      mask_ld   = 1'b0;
      capture   = 1'b0;
      done_nxt  = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               mask_ld = 1'b1;
               if (first_in[CH_W]) begin
                  state_nxt = S_CLEAR;
                  ch_nxt    = first_in[CH_W-1:0];
                  cnt_nxt   = CLEAR_LD;
               end else begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
               end
            end
         end
         S_CLEAR: if (cnt == '0) begin
            state_nxt = S_GATE;
            cnt_nxt   = GATE_LD;
         end
         S_GATE: if (cnt == '0) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = SETTLE_LD;
         end
         S_SETTLE: if (cnt == '0) state_nxt = S_CAPTURE;
         S_CAPTURE: begin
            capture = 1'b1;
            if (next_q[CH_W]) begin
               state_nxt = S_CLEAR;
               ch_nxt    = next_q[CH_W-1:0];
               cnt_nxt   = CLEAR_LD;
            end else if (cont_en) begin
               // Sweep wraps to the lowest channel; done still marks the sweep boundary.
               state_nxt = S_CLEAR;
               ch_nxt    = first_q[CH_W-1:0];
               cnt_nxt   = CLEAR_LD;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = S_DONE;
               done_nxt  = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      if (abort && state != S_IDLE && state != S_DONE) begin
         state_nxt = S_IDLE;
         capture   = 1'b0;
         done_nxt  = 1'b1;
      end

      // Outputs are decoded from the next state and registered so the oscillator enables never glitch.
      ro_enable_nxt = '0;
      if (state_nxt == S_GATE) ro_enable_nxt[ch_nxt] = 1'b1;
      ro_reset_nxt = (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) || (state_nxt == S_DONE);
      busy_nxt     = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         ch           <= '0;
         mask_q       <= '0;
         cnt          <= '0;
         ro_enable    <= '0;
         ro_reset     <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         result_ch    <= '0;
         result_count <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values.
         state        <= state_nxt;
         ch           <= ch_nxt;
         cnt          <= cnt_nxt;
         ro_enable    <= ro_enable_nxt;
         ro_reset     <= ro_reset_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         result_valid <= capture;
         if (mask_ld) mask_q <= ch_mask;
         if (capture) begin
            result_count <= ch_count;
            result_ch    <= ch;
         end
      end
   end

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Directed bench for ro_measure_sequencer with a behavioural ring-oscillator counter per channel.
// Define RO_SEQ_CONTINUOUS_EN to also exercise continuous sweeps.
`timescale 1ns/1ps
module tb_ro_measure_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [3:0]  ch_mask;
   logic [95:0] ro_count;
   logic [3:0]  ro_enable;
   logic        ro_reset, busy, done, result_valid;
   logic [1:0]  result_ch;
   logic [23:0] result_count;
`ifdef RO_SEQ_CONTINUOUS_EN
   logic        continuous;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ro_measure_sequencer #(
      .NUM_CH(4), .COUNT_W(24), .CLEAR_CYCLES(2), .GATE_CYCLES(16), .SETTLE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
      .ro_count(ro_count), .ro_enable(ro_enable), .ro_reset(ro_reset), .busy(busy),
      .done(done), .result_valid(result_valid), .result_ch(result_ch),
      .result_count(result_count)
`ifdef RO_SEQ_CONTINUOUS_EN
      , .continuous(continuous)
`endif
   );

   // Ring-oscillator model: +1 every 3 enabled clk cycles, cleared by ro_reset.
   logic [23:0] osc_cnt [4];
   logic [1:0]  osc_pre [4];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ro_reset) begin
            osc_cnt[i] <= '0;
            osc_pre[i] <= '0;
         end else if (ro_enable[i]) begin
            if (osc_pre[i] == 2'd2) begin
               osc_pre[i] <= '0;
               osc_cnt[i] <= osc_cnt[i] + 24'd1;
            end else begin
               osc_pre[i] <= osc_pre[i] + 2'd1;
            end
         end
      end
   end
   assign ro_count = {osc_cnt[3], osc_cnt[2], osc_cnt[1], osc_cnt[0]};

   // Monitor samples the cycle just ended at each rising edge.
   logic clr_mon = 1'b0;
   int   rv_ch[$];
   int   rv_cnt[$];
   int   done_cnt, onehot_bad;
   int   en_cyc[4];
   always @(posedge clk) begin
      if (clr_mon) begin
         rv_ch.delete();
         rv_cnt.delete();
         done_cnt   = 0;
         onehot_bad = 0;
         for (int i = 0; i < 4; i++) en_cyc[i] = 0;
      end else begin
         if (result_valid) begin
            rv_ch.push_back(int'(result_ch));
            rv_cnt.push_back(int'(result_count));
         end
         if (done) done_cnt++;
         if ($countones(ro_enable) > 1) onehot_bad++;
         for (int i = 0; i < 4; i++) if (ro_enable[i]) en_cyc[i]++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int q_ch(input int idx);
      return (idx < rv_ch.size()) ? rv_ch[idx] : -1;
   endfunction

   function automatic int q_cnt(input int idx);
      return (idx < rv_cnt.size()) ? rv_cnt[idx] : -1;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic clear_mon();
      clr_mon = 1'b1;
      @(negedge clk);
      clr_mon = 1'b0;
   endtask

   task automatic wait_sig(input string tag, input bit on_done, input int limit, output int n);
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         seen = on_done ? done : result_valid;
      end
      if (!seen) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ro_enable"}, ro_enable, 0);
      check({tag, "_ro_reset"}, ro_reset, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_result_valid"}, result_valid, 0);
      check({tag, "_result_ch"}, result_ch, 0);
      check({tag, "_result_count"}, result_count, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n1, n2, lows;
      reset = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = '0;
`ifdef RO_SEQ_CONTINUOUS_EN
      continuous = 1'b0;
`endif
      tick(2);
      check_reset_state("rst");
      reset = 1'b0;
      tick(1);

      // Two-channel sweep, latency and result values.
      clear_mon();
      ch_mask = 4'b0101; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t1_busy_after_start", busy, 1);
      check("t1_clear_reset", ro_reset, 1);
      wait_sig("t1_rv", 1'b0, 100, n1);
      check("t1_first_result_latency", 1 + n1, 24);
      wait_sig("t1_done", 1'b1, 100, n2);
      check("t1_done_latency", 1 + n1 + n2, 47);
      check("t1_busy_on_done", busy, 0);
      tick(1);
      check("t1_num_results", rv_ch.size(), 2);
      check("t1_ch0", q_ch(0), 0);
      check("t1_cnt0", q_cnt(0), 5);
      check("t1_ch1", q_ch(1), 2);
      check("t1_cnt1", q_cnt(1), 5);
      check("t1_done_count", done_cnt, 1);
      check("t1_en0_cycles", en_cyc[0], 16);
      check("t1_en2_cycles", en_cyc[2], 16);
      check("t1_en1_cycles", en_cyc[1], 0);
      check("t1_onehot", onehot_bad, 0);

      // Empty mask: immediate done, no results.
      clear_mon();
      ch_mask = 4'b0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t2_done", done, 1);
      check("t2_busy", busy, 0);
      check("t2_ro_enable", ro_enable, 0);
      @(negedge clk);
      check("t2_done_pulse_end", done, 0);
      tick(3);
      check("t2_no_result", rv_ch.size(), 0);
      check("t2_done_count", done_cnt, 1);

      // Abort in the 8th gate cycle of ch1.
      clear_mon();
      ch_mask = 4'b0010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tick(9);
      check("t3_gate_ch1", ro_enable, 4'b0010);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t3_abort_enable", ro_enable, 0);
      check("t3_abort_ro_reset", ro_reset, 1);
      check("t3_abort_done", done, 1);
      check("t3_abort_busy", busy, 0);
      tick(30);
      check("t3_no_result", rv_ch.size(), 0);
      check("t3_done_count", done_cnt, 1);
      check("t3_en1_cycles", en_cyc[1], 8);

      // Start pulses and mask changes mid-sweep are ignored.
      clear_mon();
      ch_mask = 4'b0110; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ch_mask = 4'b1001;
      tick(5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tick(20);
      start = 1'b1; ch_mask = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      wait_sig("t4_done", 1'b1, 200, n1);
      tick(1);
      check("t4_num_results", rv_ch.size(), 2);
      check("t4_ch0", q_ch(0), 1);
      check("t4_cnt0", q_cnt(0), 5);
      check("t4_ch1", q_ch(1), 2);
      check("t4_cnt1", q_cnt(1), 5);
      check("t4_done_count", done_cnt, 1);
      check("t4_en0_cycles", en_cyc[0], 0);
      check("t4_en3_cycles", en_cyc[3], 0);
      check("t4_onehot", onehot_bad, 0);

      // Reset during SETTLE, then a fresh sweep of ch3.
      clear_mon();
      ch_mask = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tick(19);
      check("t5_settle_enable", ro_enable, 0);
      check("t5_settle_ro_reset", ro_reset, 0);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("t5_rst");
      reset = 1'b0;
      @(negedge clk);
      ch_mask = 4'b1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_sig("t5_done", 1'b1, 200, n1);
      tick(1);
      check("t5_num_results", rv_ch.size(), 1);
      check("t5_ch", q_ch(0), 3);
      check("t5_cnt", q_cnt(0), 5);
      check("t5_result_ch_held", result_ch, 3);

`ifdef RO_SEQ_CONTINUOUS_EN
      // Continuous sweeps over ch0/ch1, stopped by dropping continuous.
      clear_mon();
      continuous = 1'b1; ch_mask = 4'b0011; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lows = 0;
      for (int k = 0; k < 92; k++) begin
         @(negedge clk);
         if (!busy) lows++;
      end
      check("t6_busy_never_low", lows, 0);
      check("t6_done_at_wrap", done, 1);
      continuous = 1'b0;
      wait_sig("t6_done", 1'b1, 200, n1);
      check("t6_stop_latency", n1, 46);
      tick(1);
      check("t6_num_results", rv_ch.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("t6_ch%0d", k), q_ch(k), k % 2);
         check($sformatf("t6_cnt%0d", k), q_cnt(k), 5);
      end
      check("t6_done_count", done_cnt, 3);
      check("t6_busy_end", busy, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
